m92_bus_decoder: RTL and testbench

Parametrised, table-driven successor to the fixed M72/M84 CPU address decoder. Decode windows are loaded at runtime by the board-config loader. Each CPU access is decoded once into a registered one-hot window select, SDRAM address and writable flag. Per-window wait states drive a `ready` handshake back to the V30/V33 bus adapter. I/O-space writes produce single-cycle strobes with the latched port number. The block sits between the CPU bus adapter and the SDRAM/video-RAM/sound-latch consumers.

---
 rtl/m92_bus_decoder.sv | 219 +++++++++++++++++++++
 tb/tb_m92_bus_decoder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m92_bus_decoder.sv
// m92_bus_decoder: runtime-loadable CPU address decoder for the M92 board.
// A table of NUM_WIN windows is written by the config loader; each CPU
// access is decoded exactly once into a registered one-hot select, SDRAM
// address and writable flag, followed by per-window wait states and a
// ready handshake. I/O-space writes produce a one-cycle strobe with the
// latched port number.
module m92_bus_decoder #(
  parameter  int ADDR_W  = 20,
  parameter  int NUM_WIN = 8,
  parameter  int SDR_W   = 25,
  parameter  int WAIT_W  = 3,
  localparam int IDX_W   = $clog2(NUM_WIN)
) (
  input  logic                CLK_32M,
  input  logic                reset_n,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic                cfg_valid,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [ADDR_W-1:0]   cfg_mask,
  input  logic [SDR_W-1:0]    cfg_sdr_base,
  input  logic                cfg_writable,
  input  logic [WAIT_W-1:0]   cfg_wait,
  input  logic [ADDR_W-1:0]   A,
  input  logic                M_IO,
  input  logic                rd,
  input  logic                wr,
  output logic [NUM_WIN-1:0]  sel,
  output logic                hit,
  output logic [SDR_W-1:0]    sdr_addr,
  output logic                writable,
  output logic                ready,
  output logic                wr_fault,
  output logic                io_wr_pulse,
  output logic [7:0]          io_port
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [IDX_W:0]  NUM_WIN_C = (IDX_W+1)'(NUM_WIN);
  localparam logic [WAIT_W-1:0] WAIT_ONE = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};

  // Decode table
  logic                valid_q    [NUM_WIN];
  logic [ADDR_W-1:0]   base_q     [NUM_WIN];
  logic [ADDR_W-1:0]   mask_q     [NUM_WIN];
  logic [SDR_W-1:0]    sdr_base_q [NUM_WIN];
  logic                wrb_q      [NUM_WIN];
  logic [WAIT_W-1:0]   wait_q     [NUM_WIN];

  // Access FSM and registered outputs
  state_e              state_q;
  logic [WAIT_W-1:0]   cnt_q;
  logic                rd_q;
  logic                wr_q;
  logic [NUM_WIN-1:0]  sel_q;
  logic                hit_q;
  logic [SDR_W-1:0]    sdr_addr_q;
  logic                writable_q;
  logic                ready_q;
  logic                wr_fault_q;
  logic                io_wr_pulse_q;
  logic [7:0]          io_port_q;

  // Combinational decode of the current address
  logic [NUM_WIN-1:0]  match_d;
  logic                hit_d;
  logic [IDX_W-1:0]    win_idx_d;
  logic [NUM_WIN-1:0]  sel_d;
  logic [SDR_W-1:0]    sdr_addr_d;
  logic                writable_d;
  logic [WAIT_W-1:0]   wait_d;
  logic                start_d;

  // Table load from the config port; out-of-range indices are dropped
  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        valid_q[i]    <= 1'b0;
        base_q[i]     <= {ADDR_W{1'b0}};
        mask_q[i]     <= {ADDR_W{1'b0}};
        sdr_base_q[i] <= {SDR_W{1'b0}};
        wrb_q[i]      <= 1'b0;
        wait_q[i]     <= {WAIT_W{1'b0}};
      end
    end else if (cfg_we && ({1'b0, cfg_idx} < NUM_WIN_C)) begin
      valid_q[cfg_idx]    <= cfg_valid;
      base_q[cfg_idx]     <= cfg_base;
      mask_q[cfg_idx]     <= cfg_mask;
      sdr_base_q[cfg_idx] <= cfg_sdr_base;
      wrb_q[cfg_idx]      <= cfg_writable;
      wait_q[cfg_idx]     <= cfg_wait;
    end
  end

  // Per-window match vector
  always_comb begin
    match_d = {NUM_WIN{1'b0}};
    for (int i = 0; i < NUM_WIN; i++) begin
      match_d[i] = valid_q[i] & (((A ^ base_q[i]) & mask_q[i]) == {ADDR_W{1'b0}});
    end
  end

  // Priority pick (lowest index wins) and derived decode values
  always_comb begin
    hit_d      = 1'b0;
    win_idx_d  = {IDX_W{1'b0}};
    sel_d      = {NUM_WIN{1'b0}};
    sdr_addr_d = {SDR_W{1'b0}};
    writable_d = 1'b0;
    wait_d     = WAIT_ZERO;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (match_d[i]) begin
        hit_d     = 1'b1;
        win_idx_d = IDX_W'(i);
      end else begin
        hit_d     = hit_d;
      end
    end
    if (hit_d) begin
      sel_d[win_idx_d] = 1'b1;
      sdr_addr_d       = sdr_base_q[win_idx_d] | SDR_W'(A & ~mask_q[win_idx_d]);
      writable_d       = wrb_q[win_idx_d];
      wait_d           = wait_q[win_idx_d];
    end else begin
      sel_d            = {NUM_WIN{1'b0}};
    end
  end

  // Rising edge of either strobe opens a new access
  always_comb begin
    start_d = (rd | wr) & ~(rd_q | wr_q);
  end

  // Access FSM: decode/latch on start, count wait states, hold ready until strobes drop.
  // The strobe history resets high so a strobe already asserted at reset release is not a start.
  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= WAIT_ZERO;
      rd_q          <= 1'b1;
      wr_q          <= 1'b1;
      sel_q         <= {NUM_WIN{1'b0}};
      hit_q         <= 1'b0;
      sdr_addr_q    <= {SDR_W{1'b0}};
      writable_q    <= 1'b0;
      ready_q       <= 1'b0;
      wr_fault_q    <= 1'b0;
      io_wr_pulse_q <= 1'b0;
      io_port_q     <= 8'h00;
    end else begin
      rd_q          <= rd;
      wr_q          <= wr;
      wr_fault_q    <= 1'b0;
      io_wr_pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_d) begin
            if (M_IO) begin
              sel_q      <= sel_d;
              hit_q      <= hit_d;
              sdr_addr_q <= sdr_addr_d;
              writable_q <= writable_d;
              wr_fault_q <= wr & ~writable_d;
              if (hit_d && (wait_d != WAIT_ZERO)) begin
                state_q <= ST_WAIT;
                cnt_q   <= wait_d - WAIT_ONE;
              end else begin
                state_q <= ST_DONE;
                ready_q <= 1'b1;
              end
            end else begin
              io_wr_pulse_q <= wr;
              if (wr) begin
                io_port_q <= A[7:0];
              end
              state_q <= ST_DONE;
              ready_q <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == WAIT_ZERO) begin
            state_q <= ST_DONE;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - WAIT_ONE;
          end
        end
        ST_DONE: begin
          if (!rd && !wr) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= WAIT_ZERO;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign sel         = sel_q;
  assign hit         = hit_q;
  assign sdr_addr    = sdr_addr_q;
  assign writable    = writable_q;
  assign ready       = ready_q;
  assign wr_fault    = wr_fault_q;
  assign io_wr_pulse = io_wr_pulse_q;
  assign io_port     = io_port_q;

endmodule

// File: tb/tb_m92_bus_decoder.sv
// Randomized self-checking bench for m92_bus_decoder. A table model and
// per-access expectations are derived from the window match rule; each
// access checks decode outputs, ready latency, pulse counts and release.
module tb_m92_bus_decoder;

  localparam int NW = 8;

  logic        CLK_32M;
  logic        reset_n;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic        cfg_valid;
  logic [19:0] cfg_base;
  logic [19:0] cfg_mask;
  logic [24:0] cfg_sdr_base;
  logic        cfg_writable;
  logic [2:0]  cfg_wait;
  logic [19:0] A;
  logic        M_IO;
  logic        rd;
  logic        wr;
  logic [7:0]  sel;
  logic        hit;
  logic [24:0] sdr_addr;
  logic        writable;
  logic        ready;
  logic        wr_fault;
  logic        io_wr_pulse;
  logic [7:0]  io_port;

  m92_bus_decoder dut (
    .CLK_32M(CLK_32M), .reset_n(reset_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid),
    .cfg_base(cfg_base), .cfg_mask(cfg_mask), .cfg_sdr_base(cfg_sdr_base),
    .cfg_writable(cfg_writable), .cfg_wait(cfg_wait),
    .A(A), .M_IO(M_IO), .rd(rd), .wr(wr),
    .sel(sel), .hit(hit), .sdr_addr(sdr_addr), .writable(writable),
    .ready(ready), .wr_fault(wr_fault), .io_wr_pulse(io_wr_pulse), .io_port(io_port)
  );

  initial CLK_32M = 1'b0;
  always #5 CLK_32M = ~CLK_32M;

  int total = 0;
  int bad   = 0;

  // reference table
  logic        t_valid [NW];
  logic [19:0] t_base  [NW];
  logic [19:0] t_mask  [NW];
  logic [24:0] t_sdr   [NW];
  logic        t_wrb   [NW];
  int          t_wait  [NW];

  // expected held outputs
  logic [7:0]  m_sel;
  logic        m_hit;
  logic [24:0] m_sdr;
  logic        m_wrb;
  logic [7:0]  m_port;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NW; i++) begin
      t_valid[i] = 1'b0; t_base[i] = 20'h0; t_mask[i] = 20'h0;
      t_sdr[i] = 25'h0; t_wrb[i] = 1'b0; t_wait[i] = 0;
    end
    m_sel = 8'h0; m_hit = 1'b0; m_sdr = 25'h0; m_wrb = 1'b0; m_port = 8'h0;
  endtask

  task automatic cfg_write(input int idx, input logic v, input logic [19:0] b, input logic [19:0] m,
                           input logic [24:0] s, input logic w, input int ws);
    @(negedge CLK_32M);
    cfg_we = 1'b1; cfg_idx = idx[2:0]; cfg_valid = v; cfg_base = b; cfg_mask = m;
    cfg_sdr_base = s; cfg_writable = w; cfg_wait = ws[2:0];
    @(negedge CLK_32M);
    cfg_we = 1'b0;
    t_valid[idx] = v; t_base[idx] = b; t_mask[idx] = m;
    t_sdr[idx] = s; t_wrb[idx] = w; t_wait[idx] = ws;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_sel"}, 64'(sel), 64'h0);
    chk({tag, "_hit"}, 64'(hit), 64'h0);
    chk({tag, "_sdr"}, 64'(sdr_addr), 64'h0);
    chk({tag, "_wrb"}, 64'(writable), 64'h0);
    chk({tag, "_rdy"}, 64'(ready), 64'h0);
    chk({tag, "_flt"}, 64'(wr_fault), 64'h0);
    chk({tag, "_iop"}, 64'(io_wr_pulse), 64'h0);
    chk({tag, "_port"}, 64'(io_port), 64'h0);
  endtask

  // one complete CPU access: strobe up, wait for ready, hold, strobe down
  task automatic access(input string tag, input logic mio, input logic iswr,
                        input logic [19:0] addr, input int hold);
    int found;
    int exp_lat;
    int exp_fault;
    int exp_pulse;
    int n_fault;
    int n_pulse;
    int n;
    logic got_ready;
    found = -1;
    exp_lat = 1;
    exp_fault = 0;
    exp_pulse = 0;
    if (mio) begin
      for (int i = 0; i < NW; i++)
        if (found < 0 && t_valid[i] && (((addr ^ t_base[i]) & t_mask[i]) == 20'h0)) found = i;
      if (found >= 0) begin
        m_sel = 8'h0; m_sel[found] = 1'b1; m_hit = 1'b1;
        m_sdr = t_sdr[found] | {5'h0, addr & ~t_mask[found]};
        m_wrb = t_wrb[found];
        exp_lat = 1 + t_wait[found];
      end else begin
        m_sel = 8'h0; m_hit = 1'b0; m_sdr = 25'h0; m_wrb = 1'b0;
      end
      exp_fault = (iswr && !m_wrb) ? 1 : 0;
    end else begin
      if (iswr) begin
        m_port = addr[7:0];
        exp_pulse = 1;
      end
    end
    @(negedge CLK_32M);
    A = addr; M_IO = mio; rd = ~iswr; wr = iswr;
    n = 0; got_ready = 1'b0; n_fault = 0; n_pulse = 0;
    while (!got_ready && n < 20) begin
      @(negedge CLK_32M);
      n++;
      n_fault += int'(wr_fault);
      n_pulse += int'(io_wr_pulse);
      if (n == 1) begin
        chk({tag, "_sel"}, 64'(sel), 64'(m_sel));
        chk({tag, "_hit"}, 64'(hit), 64'(m_hit));
        chk({tag, "_sdr"}, 64'(sdr_addr), 64'(m_sdr));
        chk({tag, "_wrb"}, 64'(writable), 64'(m_wrb));
        chk({tag, "_port"}, 64'(io_port), 64'(m_port));
      end
      got_ready = ready;
    end
    chk({tag, "_ready_lat"}, 64'(n), 64'(exp_lat));
    for (int k = 0; k < hold; k++) begin
      @(negedge CLK_32M);
      n_fault += int'(wr_fault);
      n_pulse += int'(io_wr_pulse);
      chk({tag, "_ready_hold"}, 64'(ready), 64'h1);
      chk({tag, "_sel_hold"}, 64'(sel), 64'(m_sel));
    end
    rd = 1'b0; wr = 1'b0;
    @(negedge CLK_32M);
    n_fault += int'(wr_fault);
    n_pulse += int'(io_wr_pulse);
    chk({tag, "_ready_fall"}, 64'(ready), 64'h0);
    chk({tag, "_fault_cnt"}, 64'(n_fault), 64'(exp_fault));
    chk({tag, "_iopulse_cnt"}, 64'(n_pulse), 64'(exp_pulse));
    chk({tag, "_port_end"}, 64'(io_port), 64'(m_port));
  endtask

  function automatic logic [19:0] rand_mask();
    int k;
    logic [19:0] ones;
    k = $urandom_range(19, 10);
    ones = 20'hFFFFF;
    return ones & ~((20'h1 << k) - 20'h1);
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int w;
    logic [19:0] a;
    logic [19:0] mk;
    reset_n = 1'b0; cfg_we = 1'b0; cfg_idx = 3'h0; cfg_valid = 1'b0;
    cfg_base = 20'h0; cfg_mask = 20'h0; cfg_sdr_base = 25'h0; cfg_writable = 1'b0;
    cfg_wait = 3'h0; A = 20'h0; M_IO = 1'b0; rd = 1'b0; wr = 1'b0;
    model_clear();
    repeat (3) @(negedge CLK_32M);
    check_outputs_zero("rst");
    reset_n = 1'b1;
    repeat (2) @(negedge CLK_32M);

    // directed test plan
    cfg_write(0, 1'b1, 20'h00000, 20'hC0000, 25'h0100000, 1'b0, 0);
    access("w0_read", 1'b1, 1'b0, 20'h1234A, 1);
    chk("w0_sdr_lit", 64'(m_sdr), 64'h011234A);
    cfg_write(2, 1'b1, 20'hE0000, 20'hF0000, 25'h0040000, 1'b1, 3);
    access("w2_write", 1'b1, 1'b1, 20'hE0010, 2);
    cfg_write(1, 1'b1, 20'hC0000, 20'hF0000, 25'h0200000, 1'b1, 1);
    cfg_write(3, 1'b1, 20'hC8000, 20'hFF000, 25'h0300000, 1'b0, 2);
    access("prio_13", 1'b1, 1'b0, 20'hC8000, 0);
    chk("prio_13_lit", 64'(sel), 64'h02);
    cfg_write(1, 1'b0, 20'hC0000, 20'hF0000, 25'h0200000, 1'b1, 1);
    access("prio_3", 1'b1, 1'b0, 20'hC8000, 0);
    chk("prio_3_lit", 64'(sel), 64'h08);
    access("unmapped_wr", 1'b1, 1'b1, 20'h90000, 0);
    access("io_wr_long", 1'b0, 1'b1, 20'h000C0, 9);
    chk("io_port_lit", 64'(io_port), 64'hC0);
    access("io_rd", 1'b0, 1'b0, 20'h00055, 2);

    // reset during WAIT with the strobe held
    @(negedge CLK_32M);
    A = 20'hE0010; M_IO = 1'b1; wr = 1'b1;
    repeat (2) @(negedge CLK_32M);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    model_clear();
    @(negedge CLK_32M);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK_32M);
      chk("postrst_noready", 64'(ready), 64'h0);
    end
    wr = 1'b0;
    @(negedge CLK_32M);
    access("postrst_miss", 1'b1, 1'b1, 20'hE0010, 0);
    chk("postrst_hit_lit", 64'(hit), 64'h0);

    // randomized traffic with occasional table rewrites
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(3, 0) == 0) begin
        cfg_write($urandom_range(NW - 1, 0), ($urandom_range(3, 0) != 0),
                  20'($urandom), rand_mask(), 25'($urandom),
                  1'($urandom), $urandom_range(7, 0));
      end
      w = $urandom_range(NW - 1, 0);
      mk = t_mask[w];
      if ($urandom_range(3, 0) != 0) a = (t_base[w] & mk) | (20'($urandom) & ~mk);
      else a = 20'($urandom);
      access("rnd", ($urandom_range(3, 0) != 0), 1'($urandom), a, $urandom_range(4, 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
